// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word-array data memory for the pipeline memory stage
// Ports: dr_clk/dr_rst (sync active-high); request dr_i_ce, dr_i_wr_en, dr_i_mask,
// dr_i_addr, dr_i_store_data; response dr_o_load_data, dr_o_ack, dr_o_err; dr_o_stall holds the pipe.
// Define DMEM_ALIGN_CHECK_EN to flag and suppress full-word stores with addr[1:0]!=0.
module dmem_responder #(
  parameter int DWIDTH     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              dr_clk,
  input  logic              dr_rst,
  input  logic              dr_i_ce,
  input  logic              dr_i_wr_en,
  input  logic [3:0]        dr_i_mask,
  input  logic [DWIDTH-1:0] dr_i_addr,
  input  logic [DWIDTH-1:0] dr_i_store_data,
  output logic [DWIDTH-1:0] dr_o_load_data,
  output logic              dr_o_ack,
  output logic              dr_o_stall,
  output logic              dr_o_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic wr_q, mis_q, mis, accept, commit;
  logic [3:0] mask_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DWIDTH-1:0] data_q;
  logic [DWIDTH-1:0] mem [2**DEPTH_LOG2];
  logic unused_addr;
  assign unused_addr = ^dr_i_addr;
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = dr_i_wr_en & (dr_i_mask == 4'hf) & (dr_i_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    accept     = (state == IDLE) & dr_i_ce;
    commit     = (state == BUSY) & (cnt == 4'd0);
    state_nx   = accept ? BUSY : commit ? DONE : (state == DONE) ? IDLE : state;
    // Gated by reset so a request held during reset never stalls the pipe.
    dr_o_stall = ~dr_rst & (accept | (state == BUSY));
    dr_o_ack   = state == DONE;
    dr_o_err   = (state == DONE) & mis_q;
  end
  always_ff @(posedge dr_clk) begin
    if (dr_rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      dr_o_load_data <= '0;
      mis_q          <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt    <= 4'(LATENCY - 1);
        wr_q   <= dr_i_wr_en;
        mask_q <= dr_i_mask;
        idx_q  <= dr_i_addr[DEPTH_LOG2+1:2];
        data_q <= dr_i_store_data;
        mis_q  <= mis;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !wr_q) dr_o_load_data <= mem[idx_q];
    end
  end
  always_ff @(posedge dr_clk) begin
    if (!dr_rst && commit && wr_q && !mis_q)
      for (int i = 0; i < 4; i++)
        if (mask_q[i]) mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder
module tb_dmem_responder;
  localparam int LAT = 2;
  logic dr_clk = 0, dr_rst = 0, dr_i_ce = 0, dr_i_wr_en = 0;
  logic [3:0] dr_i_mask = 0;
  logic [31:0] dr_i_addr = 0, dr_i_store_data = 0, dr_o_load_data;
  logic dr_o_ack, dr_o_stall, dr_o_err;
  logic [32:0] sb [$];
  int tests = 0, fails = 0;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1;
`else
  localparam bit ALIGN = 0;
`endif
  dmem_responder #(.DWIDTH(32), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .dr_clk(dr_clk), .dr_rst(dr_rst), .dr_i_ce(dr_i_ce), .dr_i_wr_en(dr_i_wr_en),
    .dr_i_mask(dr_i_mask), .dr_i_addr(dr_i_addr), .dr_i_store_data(dr_i_store_data),
    .dr_o_load_data(dr_o_load_data), .dr_o_ack(dr_o_ack), .dr_o_stall(dr_o_stall),
    .dr_o_err(dr_o_err));
  always #5 dr_clk = ~dr_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic req(input string tag, input bit wr, input logic [3:0] m, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_ld, input bit exp_err, input bit scramble);
    logic [32:0] e;
    bit got = 0;
    sb.push_back({exp_ld, exp_err});
    dr_i_ce = 1; dr_i_wr_en = wr; dr_i_mask = m; dr_i_addr = a; dr_i_store_data = d;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge dr_clk);
      if (dr_o_ack) begin
        got = 1;
        e = sb.pop_front();
        chk({tag, " latency"}, c, LAT + 1);
        chk({tag, " data"}, dr_o_load_data, e[32:1]);
        chk({tag, " err"}, 32'(dr_o_err), 32'(e[0]));
        chk({tag, " stall_done"}, 32'(dr_o_stall), 0);
      end else chk({tag, " stall"}, 32'(dr_o_stall), 1);
      if (scramble && c >= 1) begin
        dr_i_store_data = ~d; dr_i_mask = ~m; dr_i_addr = a ^ 32'h40;
      end
      @(posedge dr_clk); #1;
    end
    dr_i_ce = 0; dr_i_wr_en = 0;
    if (!got) chk({tag, " ack_timeout"}, 0, 1);
  endtask
  initial begin
    dr_rst = 1; dr_i_ce = 1;
    repeat (2) @(posedge dr_clk);
    @(negedge dr_clk);
    chk("rst stall", 32'(dr_o_stall), 0);
    chk("rst ack", 32'(dr_o_ack), 0);
    chk("rst load_data", dr_o_load_data, 0);
    chk("rst err", 32'(dr_o_err), 0);
    dr_i_ce = 0;
    @(posedge dr_clk); #1;
    dr_rst = 0;
    @(posedge dr_clk); #1;
    req("init20", 1, 4'hf, 32'h20, 32'h0, 32'h0, 0, 0);
    req("t2 st", 1, 4'hf, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    req("t2 ld", 0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    req("t3 st", 1, 4'b0010, 32'h11, 32'h0000AB00, 32'hDEADBEEF, 0, 1);
    req("t3 ld", 0, 4'h5, 32'h13, 32'h0, 32'hDEADABEF, 0, 0);
    req("t4 ld", 0, 4'h0, 32'h1010, 32'h0, 32'hDEADABEF, 0, 0);
    req("t4 st", 1, 4'hf, 32'hFFC, 32'h1, 32'hDEADABEF, 0, 0);
    req("t4 ld2", 0, 4'h0, 32'h1FFC, 32'h0, 32'h1, 0, 0);
    req("m0 st", 1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h1, 0, 0);
    req("m0 ld", 0, 4'h0, 32'h10, 32'h0, 32'hDEADABEF, 0, 0);
    dr_i_ce = 1; dr_i_wr_en = 1; dr_i_mask = 4'hf; dr_i_addr = 32'h20; dr_i_store_data = 32'h12345678;
    @(posedge dr_clk); #1;
    dr_rst = 1; dr_i_ce = 0; dr_i_wr_en = 0;
    @(posedge dr_clk); #1;
    dr_rst = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge dr_clk);
      chk("t5 no_ack", 32'(dr_o_ack), 0);
      @(posedge dr_clk); #1;
    end
    req("t5 ld", 0, 4'h0, 32'h20, 32'h0, 32'h0, 0, 0);
    req("t6 st", 1, 4'hf, 32'h13, 32'hCAFEF00D, 32'h0, ALIGN, 0);
    req("t6 ld", 0, 4'h0, 32'h10, 32'h0, ALIGN ? 32'hDEADABEF : 32'hCAFEF00D, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
